// File: rtl/rx_checker_pkg.sv
// Shared definitions for the sequence/gap receive checker: FSM encoding,
// error-code bit positions and default widths.
package rx_checker_pkg;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TRACK      = 1'b1
  } state_e;

  localparam int ERR_DATA_BIT = 0;
  localparam int ERR_GAP_BIT  = 1;
  localparam int ERR_CODE_W   = 2;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_GAP_W    = 8;
  localparam int DEF_CNT_W    = 16;
  localparam int ERR_CNT_W    = 8;

endpackage

// File: rtl/rx_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Clear wins over increment; the count holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_checker.sv
// Receive checker: locks on the first beat, then flags data-sequence breaks and
// too-short idle gaps between beats, keeping counts and gap statistics. One-cycle latency.
module rx_checker
  import rx_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data,
  input  logic                  en,
  input  logic [GAP_W-1:0]      gap_min,
  output logic                  locked,
  output logic [DATA_W-1:0]     last_data,
  output logic [CNT_W-1:0]      rcv_count,
  output logic                  err,
  output logic [ERR_CODE_W-1:0] err_code,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [GAP_W-1:0]      gap_min_seen,
  output logic [GAP_W-1:0]      gap_max_seen
);

  state_e                  state_d, state_q;
  logic                    locked_d, locked_q;
  logic [DATA_W-1:0]       last_data_d, last_data_q;
  logic [DATA_W-1:0]       expected_d, expected_q;
  logic                    err_d, err_q;
  logic [ERR_CODE_W-1:0]   err_code_d, err_code_q;
  logic [GAP_W-1:0]        gap_min_seen_d, gap_min_seen_q;
  logic [GAP_W-1:0]        gap_max_seen_d, gap_max_seen_q;

  logic                    gap_inc, gap_clr, rcv_inc, err_inc;
  logic [GAP_W-1:0]        gap_cnt;

  always_comb begin
    state_d        = state_q;
    locked_d       = locked_q;
    last_data_d    = last_data_q;
    expected_d     = expected_q;
    err_d          = 1'b0;
    err_code_d     = '0;
    gap_min_seen_d = gap_min_seen_q;
    gap_max_seen_d = gap_max_seen_q;
    gap_inc        = 1'b0;
    gap_clr        = 1'b0;
    rcv_inc        = 1'b0;
    err_inc        = 1'b0;

    case (state_q)
      WAIT_FIRST: begin
        if (en) begin
          last_data_d = data;
          expected_d  = data + DATA_W'(1);
          locked_d    = 1'b1;
          gap_clr     = 1'b1;
          rcv_inc     = 1'b1;
          state_d     = TRACK;
        end
      end
      TRACK: begin
        if (en) begin
          // gap_cnt here is the idle-cycle count since the previous beat
          gap_clr     = 1'b1;
          rcv_inc     = 1'b1;
          last_data_d = data;
          expected_d  = data + DATA_W'(1);
          err_code_d[ERR_DATA_BIT] = (data != expected_q);
          err_code_d[ERR_GAP_BIT]  = (gap_min != '0) && (gap_cnt < gap_min);
          err_d       = |err_code_d;
          err_inc     = |err_code_d;
          if (gap_cnt < gap_min_seen_q) gap_min_seen_d = gap_cnt;
          if (gap_cnt > gap_max_seen_q) gap_max_seen_d = gap_cnt;
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WAIT_FIRST;
      locked_q       <= 1'b0;
      last_data_q    <= '0;
      expected_q     <= '0;
      err_q          <= 1'b0;
      err_code_q     <= '0;
      gap_min_seen_q <= '1;
      gap_max_seen_q <= '0;
    end else begin
      state_q        <= state_d;
      locked_q       <= locked_d;
      last_data_q    <= last_data_d;
      expected_q     <= expected_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      gap_min_seen_q <= gap_min_seen_d;
      gap_max_seen_q <= gap_max_seen_d;
    end
  end

  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (gap_inc),
    .clear (gap_clr),
    .cnt   (gap_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rcv_inc),
    .clear (1'b0),
    .cnt   (rcv_count)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clear (1'b0),
    .cnt   (err_count)
  );

  assign locked       = locked_q;
  assign last_data    = last_data_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign gap_min_seen = gap_min_seen_q;
  assign gap_max_seen = gap_max_seen_q;

endmodule

// File: tb/tb_rx_checker.sv
// Directed table-driven bench for rx_checker with hand sequences for
// gap saturation, error-count saturation and reset coincident with a beat.
module tb_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  data;
  logic        en;
  logic [7:0]  gap_min;
  logic        locked;
  logic [3:0]  last_data;
  logic [15:0] rcv_count;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic [7:0]  gap_min_seen;
  logic [7:0]  gap_max_seen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_checker dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .en           (en),
    .gap_min      (gap_min),
    .locked       (locked),
    .last_data    (last_data),
    .rcv_count    (rcv_count),
    .err          (err),
    .err_code     (err_code),
    .err_count    (err_count),
    .gap_min_seen (gap_min_seen),
    .gap_max_seen (gap_max_seen)
  );

  typedef struct {
    bit         rst_before;
    int         gap;
    logic [7:0] gmin;
    logic [3:0] d;
    logic       e_err;
    logic [1:0] e_code;
    logic [7:0] e_ec;
    logic [3:0] e_last;
    logic [15:0] e_rcv;
    logic [7:0] e_gmin;
    logic [7:0] e_gmax;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    en   = 1'b1;
    data = d;
    tick();
    en   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_locked"},    locked, 0);
    chk({tag, "_last"},      last_data, 0);
    chk({tag, "_rcv"},       rcv_count, 0);
    chk({tag, "_err"},       err, 0);
    chk({tag, "_code"},      err_code, 0);
    chk({tag, "_errcnt"},    err_count, 0);
    chk({tag, "_gmin_seen"}, gap_min_seen, 255);
    chk({tag, "_gmax_seen"}, gap_max_seen, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data = '0; gap_min = '0;

    //          rst gap gmin d  err code ec last rcv gmin gmax
    vt[0]  = '{1, 0, 2,  5, 0, 0, 0, 5,  1, 255, 0};
    vt[1]  = '{0, 3, 2,  6, 0, 0, 0, 6,  2, 3,   3};
    vt[2]  = '{0, 3, 2,  7, 0, 0, 0, 7,  3, 3,   3};
    vt[3]  = '{1, 0, 2, 14, 0, 0, 0, 14, 1, 255, 0};
    vt[4]  = '{0, 4, 2, 15, 0, 0, 0, 15, 2, 4,   4};
    vt[5]  = '{0, 4, 2,  0, 0, 0, 0, 0,  3, 4,   4};
    vt[6]  = '{0, 4, 2,  1, 0, 0, 0, 1,  4, 4,   4};
    vt[7]  = '{1, 0, 2,  3, 0, 0, 0, 3,  1, 255, 0};
    vt[8]  = '{0, 5, 2,  4, 0, 0, 0, 4,  2, 5,   5};
    vt[9]  = '{0, 5, 2,  9, 1, 1, 1, 9,  3, 5,   5};
    vt[10] = '{0, 5, 2, 10, 0, 0, 1, 10, 4, 5,   5};
    vt[11] = '{1, 0, 4,  1, 0, 0, 0, 1,  1, 255, 0};
    vt[12] = '{0, 1, 4,  2, 1, 2, 1, 2,  2, 1,   1};
    vt[13] = '{0, 0, 4,  7, 1, 3, 2, 7,  3, 0,   1};
    vt[14] = '{0, 0, 4,  9, 1, 3, 3, 9,  4, 0,   1};
    vt[15] = '{0, 0, 0, 10, 0, 0, 3, 10, 5, 0,   1};

    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 16; i++) begin
      if (vt[i].rst_before) do_reset();
      gap_min = vt[i].gmin;
      if (vt[i].gap > 0) begin
        tick();
        chk($sformatf("v%0d_err_idle", i), err, 0);
        chk($sformatf("v%0d_code_idle", i), err_code, 0);
        repeat (vt[i].gap - 1) tick();
      end
      send(vt[i].d);
      chk($sformatf("v%0d_locked", i),    locked, 1);
      chk($sformatf("v%0d_err", i),       err, vt[i].e_err);
      chk($sformatf("v%0d_code", i),      err_code, vt[i].e_code);
      chk($sformatf("v%0d_errcnt", i),    err_count, vt[i].e_ec);
      chk($sformatf("v%0d_last", i),      last_data, vt[i].e_last);
      chk($sformatf("v%0d_rcv", i),       rcv_count, vt[i].e_rcv);
      chk($sformatf("v%0d_gmin_seen", i), gap_min_seen, vt[i].e_gmin);
      chk($sformatf("v%0d_gmax_seen", i), gap_max_seen, vt[i].e_gmax);
    end

    // Long idle saturates the gap counter at 255; 255 >= gap_min so no error.
    do_reset();
    gap_min = 8'd10;
    send(4'd3);
    repeat (300) tick();
    send(4'd4);
    chk("long_err",       err, 0);
    chk("long_gmax_seen", gap_max_seen, 255);
    chk("long_gmin_seen", gap_min_seen, 255);
    chk("long_rcv",       rcv_count, 2);

    // Reset mid-gap together with a beat: beat must be dropped.
    repeat (5) tick();
    rst  = 1'b1;
    en   = 1'b1;
    data = 4'd7;
    tick();
    chk_reset_state("rst_beat");
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) tick();
    chk("relock_pre_locked", locked, 0);
    send(4'd12);
    chk("relock_locked", locked, 1);
    chk("relock_last",   last_data, 12);
    chk("relock_rcv",    rcv_count, 1);
    chk("relock_err",    err, 0);
    chk("relock_errcnt", err_count, 0);

    // Repeated data 0 with expected 1: every beat errs; count must stop at 255.
    do_reset();
    gap_min = 8'd0;
    send(4'd0);
    for (int k = 0; k < 260; k++) send(4'd0);
    chk("sat_err",    err, 1);
    chk("sat_code",   err_code, 1);
    chk("sat_errcnt", err_count, 255);
    chk("sat_rcv",    rcv_count, 261);
    tick();
    chk("sat_err_drop",  err, 0);
    chk("sat_code_drop", err_code, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_checker.md
RX_CHECKER -- requirements
Module: rx_checker

Interface
REQ-001 Parameter DATA_W, default 4, width of the sequence data word.
REQ-002 Parameter GAP_W, default 8, width of gap counter and gap statistics.
REQ-003 Parameter CNT_W, default 16, width of the received-beat counter.
REQ-004 Port clk  input  1  single clock; all logic rises on posedge clk.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port data  input  DATA_W  sequence word, valid only when en=1.
REQ-007 Port en  input  1  single-cycle strobe marking one received beat.
REQ-008 Port gap_min  input  GAP_W  minimum legal idle cycles between consecutive en strobes.
REQ-009 Port locked  output  1  high once the first beat after reset is captured.
REQ-010 Port last_data  output  DATA_W  data of the most recent beat.
REQ-011 Port rcv_count  output  CNT_W  beats received since reset, saturating.
REQ-012 Port err  output  1  one-cycle pulse per offending beat.
REQ-013 Port err_code  output  2  bit0 data mismatch, bit1 gap violation; valid with err, else 0.
REQ-014 Port err_count  output  8  offending beats since reset, saturating at 255.
REQ-015 Port gap_min_seen  output  GAP_W  smallest measured gap.
REQ-016 Port gap_max_seen  output  GAP_W  largest measured gap.

Function
REQ-017 All outputs registered; effects of a beat sampled at edge N are visible after edge N (one-cycle latency).
REQ-018 FSM states: WAIT_FIRST, TRACK; reset enters WAIT_FIRST.
REQ-019 WAIT_FIRST + en: last_data<=data, expected<=data+1, rcv_count<=1, locked<=1, gap_cnt<=0, go TRACK; no checks, no error.
REQ-020 WAIT_FIRST without en: all state held.
REQ-021 TRACK, no en: gap_cnt increments, saturating at 2^GAP_W-1.
REQ-022 TRACK + en: measured gap = current gap_cnt (idle cycles since previous beat; back-to-back strobes give 0); gap_cnt<=0.
REQ-023 Data check: data != expected sets err_code bit0; expected always reloads to data+1 (resync, no cascade errors).
REQ-024 Gap check: measured gap < gap_min sets err_code bit1; gap_min=0 disables the check.
REQ-025 Either bit set: err pulses 1 cycle, err_count +1 once per beat even when both bits set.
REQ-026 Expected arithmetic modulo 2^DATA_W: expected after 15 is 0 (DATA_W=4), not an error.
REQ-027 gap_min_seen<=min(gap_min_seen, gap), gap_max_seen<=max(gap_max_seen, gap) on every TRACK beat; saturated gap used as is.
REQ-028 rcv_count increments per beat, holds at 2^CNT_W-1; err_count holds at 255.
REQ-029 gap_min changes take effect at the next beat; no latching.
REQ-030 FSM never leaves TRACK except via reset.

Reset
REQ-031 rst asserted at any time, including mid-gap or coincident with en, forces: state WAIT_FIRST, locked 0, last_data 0, rcv_count 0, err 0, err_code 0, err_count 0, gap_cnt 0, gap_min_seen all-ones, gap_max_seen 0, expected 0.
REQ-032 A beat coincident with an active rst is discarded; first beat after release relocks per REQ-019.

Structure
REQ-033 Shared package rx_checker_pkg holds FSM state encoding, err_code bit positions, default widths.
REQ-034 One sub-module, sat_counter (parameterized width, inc, clear, async rst), instantiated for gap_cnt, rcv_count, err_count.

Verification
REQ-035 Reset, beats data 5,6,7 with gaps 3 and gap_min=2 -> locked=1, rcv_count=3, err_count=0, gap_min_seen=3, gap_max_seen=3.
REQ-036 Beats 14,15,0,1 with gaps 4, gap_min=2 -> no err; last_data=1.
REQ-037 Beats 3,4,9,10 gaps 5 -> single err pulse on beat 9, err_code=01, err_count=1; beat 10 clean.
REQ-038 gap_min=4, beats 1,2 with gap 1 -> err_code=10; beats 7,9 with gap 0 -> err_code=11, err_count increments by one per beat.
REQ-039 Beat after 300 idle cycles -> gap_max_seen=255, no err with gap_min=10.
REQ-040 Assert rst mid-gap coincident with en -> all outputs reset, beat ignored; next beat 12 relocks, last_data=12, rcv_count=1, no err.
